axil_cfg_write_master: RTL and testbench
========================================

Name: axil_cfg_write_master

Overview:
- Parametrised AXI4-Lite write master that programs DMA/peripheral registers on behalf of NUM_REQ independent requestors (sequencer slots, read/write DMA channels).
- Arbitrates requestors round-robin and computes each address as base + per-request offset.
- Drives AW and W concurrently with independent handshakes, then waits for B.
- Reports per-requestor done, plus error on a non-OKAY response or on response timeout.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- OFF_WIDTH, 8, register offset width per request.
- NUM_REQ, 8, number of requestors (≥1).
- TIMEOUT_CYCLES, 1024, B-wait limit; 0 disables the timeout.
- TO_CNT_WIDTH, 11, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- base_addr  in  ADDR_WIDTH  target register-block base address
- req_valid  in  NUM_REQ  per-requestor level request; held until done
- req_offset  in  NUM_REQ*OFF_WIDTH  flattened byte offsets; slice i belongs to requestor i
- req_data  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_strb  in  NUM_REQ*(DATA_WIDTH/8)  flattened byte strobes
- done  out  NUM_REQ  one-cycle completion pulse, one-hot
- err  out  NUM_REQ  valid with done: transaction failed
- err_code  out  2  valid with done: latched BRESP, or 2'b11 on timeout
- busy  out  1  high whenever state != IDLE
- M_AXI_AWADDR  out  ADDR_WIDTH
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_AWPROT  out  3  tied 3'b000
- M_AXI_WDATA  out  DATA_WIDTH
- M_AXI_WSTRB  out  DATA_WIDTH/8
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1

Behaviour:
- Reset (async, active-low): state=IDLE, rr_ptr=0, aw_pend=w_pend=0, timeout counter=0. All outputs 0, including AWADDR/WDATA/WSTRB, which are registered.
- IDLE:
  - If req_valid!=0, the arbiter picks the first set bit at or above rr_ptr, wrapping modulo NUM_REQ.
  - Register grant (one-hot), AWADDR = base_addr + zero-extended offset (modulo 2^ADDR_WIDTH), WDATA and WSTRB.
  - Set aw_pend=w_pend=1 and go to ISSUE. One cycle from request to AWVALID.
- ISSUE:
  - AWVALID=aw_pend and WVALID=w_pend.
  - aw_pend clears on AWVALID&AWREADY; w_pend clears on WVALID&WREADY. Either order, or the same cycle.
  - Address, data and strobe stay stable while the corresponding valid is high. Valids are never withdrawn before the handshake.
  - When both are cleared (computed on next-state values, so a same-cycle double handshake moves directly), go to RESP and clear the counter.
- RESP:
  - BREADY=1.
  - On BVALID: latch BRESP and go to DONE.
  - Otherwise, if TIMEOUT_CYCLES>0, increment the counter. At TIMEOUT_CYCLES-1 go to DONE with err_code=2'b11.
- DONE (1 cycle):
  - done=grant.
  - err=grant if err_code!=2'b00.
  - rr_ptr = granted index+1, wrapping NUM_REQ-1→0.
  - Return to IDLE. Back-to-back requests therefore have one idle cycle between DONE and the next ISSUE.
- Requestor rules:
  - req_valid must be dropped in the cycle after its done pulse. If it is still high, that is a new request and will be re-served.
  - Dropping req_valid mid-transaction is ignored: the transaction completes and done still pulses.
  - Changing req_* data after grant has no effect.
- Timeout is terminal for protocol correctness. A late BVALID after a timeout is not accepted (BREADY=0 outside RESP), and recovery requires reset. This is documented for system integration.
- Reset mid-transaction drops valids immediately. This is permitted only with a simultaneous interconnect reset.
- Strobe: req_strb is passed through unmodified, and WSTRB=0 is legal.
- NUM_REQ=1: the arbiter degenerates to a constant grant; rr_ptr width is max(1,clog2(NUM_REQ)).

Decomposition:
- Package axil_cfg_pkg:
  - State encodings IDLE/ISSUE/RESP/DONE.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - ERR_TIMEOUT=2'b11.
  - Width helper function clog2.
- Sub-module rr_arbiter (NUM_REQ): combinational pick given req and rr_ptr, outputting a one-hot grant and a binary index. Pointer update stays in the parent.

Test Plan:
- Single write, slave ready immediately: base=0x4000_0000, req_valid=8'h04, offset[2]=0x18, data=0xDEAD_BEEF → AW/W handshake with AWADDR=0x4000_0018, BRESP=0 → done=8'h04, err=0; AW and W valid exactly one cycle each.
- Decoupled handshakes: WREADY high 3 cycles before AWREADY, then the reverse order → valids and payload stable until each handshake; single B; one done pulse.
- Round-robin fairness: req_valid=8'hFF held, re-asserted after each done → grant order 0,1,…,7,0; then rr_ptr=5 with req_valid=8'h21 → grant 5, then 0.
- Error response: slave returns BRESP=2'b10 → done and err set for the granted bit, err_code=2'b10; the next request proceeds normally.
- Timeout: TIMEOUT_CYCLES=16, BVALID never asserted → done+err, err_code=2'b11, exactly 16 cycles after entering RESP; BREADY deasserts.
- Async reset asserted mid-ISSUE → all outputs 0 within the same cycle, IDLE after release, no done pulse.

Source files
------------

// File: rtl/axil_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite configuration write master.
// Latency: none (declarations only).
// Backpressure: n/a.
package axil_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Ceiling log2, used to size index and pointer fields.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axil_cfg_write_master_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping to bit 0.
// Latency: combinational.
// Backpressure: none; the parent decides when the pick is taken.
module rr_arbiter
  import axil_cfg_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  // Two passes: upper segment from ptr first, then wrap around from bit 0.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/axil_cfg_write_master.sv
// AXI4-Lite single-beat write master serving NUM_REQ requestors round-robin.
// Latency: AWVALID/WVALID one cycle after request; done one cycle after B (or timeout).
// Backpressure: AW/W valids held until each handshake; B waited for up to TIMEOUT_CYCLES.
module axil_cfg_write_master
  import axil_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int OFF_WIDTH      = 8,
  parameter int NUM_REQ        = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_WIDTH   = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*OFF_WIDTH-1:0]    req_offset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]              done,
  output logic [NUM_REQ-1:0]              err,
  output logic [1:0]                      err_code,
  output logic                            busy,
  output logic [ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  localparam int IDX_W  = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
    TO_CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        rr_ptr, gnt_idx, arb_idx;
  logic [NUM_REQ-1:0]      grant, arb_grant;
  logic                    aw_pend, w_pend, aw_pend_nxt, w_pend_nxt;
  logic [TO_CNT_WIDTH-1:0] to_cnt;
  logic [1:0]              code_q;
  logic                    to_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (state == ISSUE) && aw_pend;
  assign M_AXI_WVALID  = (state == ISSUE) && w_pend;
  assign M_AXI_BREADY  = (state == RESP);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE) ? grant : '0;
  assign err           = ((state == DONE) && (code_q != RESP_OKAY)) ? grant : '0;
  assign err_code      = (state == DONE) ? code_q : RESP_OKAY;

  // Pending flags after this cycle's handshakes; lets a double handshake leave ISSUE at once.
  assign aw_pend_nxt = aw_pend && !(M_AXI_AWVALID && M_AXI_AWREADY);
  assign w_pend_nxt  = w_pend && !(M_AXI_WVALID && M_AXI_WREADY);
  assign to_hit      = TO_EN && (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = ISSUE;
      ISSUE:   if (!aw_pend_nxt && !w_pend_nxt) state_nxt = RESP;
      RESP:    if (M_AXI_BVALID || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, registered AXI payload, pending flags, timeout and pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant        <= '0;
      gnt_idx      <= '0;
      rr_ptr       <= '0;
      aw_pend      <= 1'b0;
      w_pend       <= 1'b0;
      to_cnt       <= '0;
      code_q       <= RESP_OKAY;
      M_AXI_AWADDR <= '0;
      M_AXI_WDATA  <= '0;
      M_AXI_WSTRB  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant        <= arb_grant;
            gnt_idx      <= arb_idx;
            M_AXI_AWADDR <= base_addr +
                            ADDR_WIDTH'(req_offset[arb_idx*OFF_WIDTH +: OFF_WIDTH]);
            M_AXI_WDATA  <= req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            M_AXI_WSTRB  <= req_strb[arb_idx*STRB_W +: STRB_W];
            aw_pend      <= 1'b1;
            w_pend       <= 1'b1;
          end
        end
        ISSUE: begin
          aw_pend <= aw_pend_nxt;
          w_pend  <= w_pend_nxt;
          if (!aw_pend_nxt && !w_pend_nxt) to_cnt <= '0;
        end
        RESP: begin
          if (M_AXI_BVALID)  code_q <= M_AXI_BRESP;
          else if (to_hit)   code_q <= ERR_TIMEOUT;
          else if (TO_EN)    to_cnt <= to_cnt + 1'b1;
        end
        DONE: begin
          rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_write_master.sv
// Randomised bench for axil_cfg_write_master with a queue-based scoreboard.
// Latency: expectations are ordered per round, independent of cycle timing.
// Backpressure: slave model applies per-transaction AW/W/B delays.
module tb_axil_cfg_write_master;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int OW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   base_addr = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N*OW-1:0] req_offset = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*SW-1:0] req_strb = '0;
  logic [N-1:0]    done, err;
  logic [1:0]      err_code;
  logic            busy;
  logic [AW-1:0]   awaddr;
  logic            awvalid, wvalid, bready;
  logic            awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]      bresp = 2'b00;
  logic [2:0]      awprot;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;

  axil_cfg_write_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFF_WIDTH(OW), .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO), .TO_CNT_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .req_valid(req_valid),
    .req_offset(req_offset), .req_data(req_data), .req_strb(req_strb),
    .done(done), .err(err), .err_code(err_code), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_AWPROT(awprot), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  typedef struct { logic [AW-1:0] addr; int cyc; } aw_exp_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; int cyc; } w_exp_t;
  typedef struct { int idx; logic [1:0] code; bit tmo; } done_exp_t;
  typedef struct { int awd; int wd; int bd; logic [1:0] resp; bit nob; } slv_t;

  aw_exp_t   exp_aw[$];
  w_exp_t    exp_w[$];
  done_exp_t exp_done[$];
  slv_t      slv_q[$];

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;
  logic [OW-1:0] off_a [N];
  logic [DW-1:0] dat_a [N];
  logic [SW-1:0] strb_a [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT produced an event with no expectation queued", name);
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  int aw_cyc = 0, w_cyc = 0, resp_cyc = 0;
  always @(negedge clk) begin
    if (!reset) begin
      exp_aw.delete(); exp_w.delete(); exp_done.delete();
      aw_cyc = 0; w_cyc = 0; resp_cyc = 0;
    end else begin
      if (awvalid) begin
        if (exp_aw.size() == 0) unexpected("aw_valid");
        else begin
          chk("awaddr", awaddr, exp_aw[0].addr);
          aw_cyc++;
          if (awready) begin
            chk("aw_valid_cycles", aw_cyc, exp_aw[0].cyc);
            void'(exp_aw.pop_front());
            aw_cyc = 0;
          end
        end
      end
      if (wvalid) begin
        if (exp_w.size() == 0) unexpected("w_valid");
        else begin
          chk("wdata", wdata, exp_w[0].data);
          chk("wstrb", wstrb, exp_w[0].strb);
          w_cyc++;
          if (wready) begin
            chk("w_valid_cycles", w_cyc, exp_w[0].cyc);
            void'(exp_w.pop_front());
            w_cyc = 0;
          end
        end
      end
      if (bready) resp_cyc++;
      if (done != '0) begin
        if (exp_done.size() == 0) unexpected("done");
        else begin
          done_exp_t e;
          logic [N-1:0] oh;
          e  = exp_done.pop_front();
          oh = N'(1) << e.idx;
          chk("done", done, oh);
          chk("err", err, (e.code != 2'b00) ? oh : '0);
          chk("err_code", err_code, e.code);
          chk("busy_at_done", busy, 1'b1);
          if (e.tmo) begin
            chk("timeout_resp_cycles", resp_cyc, TO);
            chk("bready_low_at_timeout_done", bready, 1'b0);
          end
        end
        resp_cyc = 0;
      end
    end
  end

  // Slave model: per-transaction ready delays and B response, driven mid-cycle.
  initial begin
    slv_t cur;
    bit have = 0, aw_ok = 0, w_ok = 0, both;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    cur = '{0, 0, 0, 2'b00, 1'b0};
    forever begin
      @(posedge clk); #2;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      if (!reset) begin
        have = 0; slv_q.delete();
      end else begin
        if (!have && (awvalid || wvalid) && slv_q.size() > 0) begin
          cur = slv_q.pop_front();
          have = 1; aw_ok = 0; w_ok = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end
        if (have) begin
          both = aw_ok && w_ok;
          if (awvalid && !aw_ok) begin
            if (aw_cnt >= cur.awd) begin awready = 1'b1; aw_ok = 1; end
            else aw_cnt++;
          end
          if (wvalid && !w_ok) begin
            if (w_cnt >= cur.wd) begin wready = 1'b1; w_ok = 1; end
            else w_cnt++;
          end
          if (both) begin
            if (cur.nob) have = 0;
            else if (b_cnt >= cur.bd) begin
              bvalid = 1'b1; bresp = cur.resp;
              if (bready) have = 0;
            end else b_cnt++;
          end
        end
      end
    end
  end

  // Drive one round: assert mask, predict service order from the round-robin rule,
  // drop each requestor's bit when its done arrives.  rsp: -1 random, 0..3 fixed, 4 no B.
  task automatic run_round(input logic [N-1:0] mask, input int awd, input int wd,
                           input int rsp, input bit rnd);
    int p, j, last, cyc;
    slv_t s;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        off_a[i] = OW'($urandom); dat_a[i] = $urandom; strb_a[i] = SW'($urandom_range(0, 15));
      end
    end
    for (int i = 0; i < N; i++) begin
      req_offset[i*OW +: OW] = off_a[i];
      req_data[i*DW +: DW]   = dat_a[i];
      req_strb[i*SW +: SW]   = strb_a[i];
    end
    p = model_ptr; last = p;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (mask[j]) begin
        s.awd  = (awd < 0) ? int'($urandom_range(0, 3)) : awd;
        s.wd   = (wd < 0) ? int'($urandom_range(0, 3)) : wd;
        s.bd   = int'($urandom_range(0, 2));
        s.nob  = (rsp == 4);
        s.resp = (rsp < 0) ? 2'($urandom_range(0, 3)) : (s.nob ? 2'b00 : 2'(rsp));
        slv_q.push_back(s);
        exp_aw.push_back('{base_addr + {{(AW-OW){1'b0}}, off_a[j]}, s.awd + 1});
        exp_w.push_back('{dat_a[j], strb_a[j], s.wd + 1});
        exp_done.push_back('{j, s.nob ? 2'b11 : s.resp, s.nob});
        last = j;
      end
    end
    model_ptr = (last + 1) % N;
    req_valid = mask;
    cyc = 0;
    while (req_valid != '0) begin
      @(posedge clk); #2;
      req_valid &= ~done;
      cyc++;
      if (cyc > 400) begin
        checks++; failures++;
        $display("FAIL round_budget: requests 0x%0h still pending after %0d cycles", req_valid, cyc);
        finish_tb();
      end
    end
    @(posedge clk); #2;
    chk("idle_after_round", busy, 1'b0);
    chk("queues_drained", 64'(exp_done.size() + exp_aw.size() + exp_w.size()), 0);
  endtask

  initial begin
    #500000;
    checks++; failures++;
    $display("FAIL watchdog: simulation did not finish in time, got hang expected finish");
    finish_tb();
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_valids", {awvalid, wvalid, bready}, 3'b000);
    chk("reset_payload", {awaddr, wdata}, 64'h0);
    chk("reset_strb_prot", {wstrb, awprot}, 7'h0);
    chk("reset_done_err", {done, err, err_code}, 18'h0);
    @(posedge clk); #4 reset = 1'b1;
    @(posedge clk); #2;

    // Single write, slave ready immediately.
    base_addr = 32'h4000_0000;
    off_a[2] = 8'h18; dat_a[2] = 32'hDEAD_BEEF; strb_a[2] = 4'hF;
    run_round(8'h04, 0, 0, 0, 0);
    // Decoupled handshakes: W first by 3 cycles, then AW first by 3 cycles.
    run_round(8'h04, 3, 0, 0, 0);
    run_round(8'h04, 0, 3, 0, 0);
    // Fairness: all requestors, then pointer parked at 5 with requests 5 and 0.
    run_round(8'hFF, 0, 0, 0, 1);
    run_round(8'hFF, -1, -1, 0, 1);
    run_round(8'h10, 0, 0, 0, 1);
    run_round(8'h21, 0, 0, 0, 1);
    // Error response, then a clean follow-up.
    run_round(8'h02, 0, 0, 2, 1);
    run_round(8'h02, 0, 0, 0, 1);
    // Random traffic including address wrap and all response codes.
    for (int r = 0; r < 25; r++) begin
      base_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      run_round(N'($urandom_range(1, 255)), -1, -1, -1, 1);
    end
    // Timeout with BVALID never asserted.
    run_round(8'h08, 0, 0, 4, 1);
    run_round(8'h08, 1, 2, 0, 1);

    // Reset while AW/W are outstanding.
    slv_q.push_back('{50, 50, 0, 2'b00, 1'b1});
    exp_aw.push_back('{base_addr + {{(AW-OW){1'b0}}, off_a[6]}, 0});
    exp_w.push_back('{dat_a[6], strb_a[6], 0});
    exp_done.push_back('{6, 2'b11, 1'b1});
    req_valid = 8'h40;
    for (int c = 0; c < 5 && !awvalid; c++) begin @(posedge clk); #2; end
    chk("issue_before_reset", {awvalid, wvalid}, 2'b11);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("midreset_valids", {awvalid, wvalid, bready, busy}, 4'b0000);
    chk("midreset_payload", {awaddr, wdata}, 64'h0);
    chk("midreset_done", {done, err, err_code, wstrb}, 22'h0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #4 reset = 1'b1;
    model_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      chk("post_reset_idle", {busy, done}, 9'h0);
    end
    run_round(N'($urandom_range(1, 255)), -1, -1, -1, 1);
    finish_tb();
  end

endmodule
